// File: rtl/axis_pkt_scheduler.sv
// axis_pkt_scheduler
//   Weighted round-robin packet scheduler for a multi-source AXIS FIFO mux. It
//   issues a registered one-hot grant selecting the source FIFO that drives the
//   shared output stream. Arbitration happens only on packet boundaries. Each
//   source gets up to weight[i] consecutive packets per turn (0 acts as 1). An
//   idle-grant timeout releases the bus from an owner with nothing to send.
//
// Ports
//   clk              clock
//   rst              synchronous active-high reset
//   i_req            per-source "head of FIFO valid"
//   i_weight         packed per-source packet quota, source i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   i_beat           output handshake (m_valid && m_ready)
//   i_last           m_last qualifier for i_beat
//   o_grant          one-hot grant, zero when idle
//   o_grant_valid    |o_grant
//   o_timeout        one-cycle pulse when a grant is revoked by timeout
//
// Optional build macro AXIS_PKT_SCHED_STATS_EN adds:
//   i_stat_clr       synchronous clear of the statistics counters
//   o_stat_pkts      per-source completed-packet count, 16 bits each, saturating
//   o_stat_timeouts  total timeout count, 16 bits, saturating
module axis_pkt_scheduler #(
  parameter int unsigned NREQ            = 4,
  parameter int unsigned WEIGHT_WIDTH    = 4,
  parameter int unsigned TIMEOUT_CNT_MAX = 128
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef AXIS_PKT_SCHED_STATS_EN
  input  logic                         i_stat_clr,
  output logic [NREQ*16-1:0]           o_stat_pkts,
  output logic [15:0]                  o_stat_timeouts,
`endif
  input  logic [NREQ-1:0]              i_req,
  input  logic [NREQ*WEIGHT_WIDTH-1:0] i_weight,
  input  logic                         i_beat,
  input  logic                         i_last,
  output logic [NREQ-1:0]              o_grant,
  output logic                         o_grant_valid,
  output logic                         o_timeout
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CNT_MAX);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e                  r_state, w_state_nxt;
  logic [NREQ-1:0]         r_grant, w_grant_nxt;
  logic [IdxW-1:0]         r_last_served, w_last_served_nxt;
  logic [WEIGHT_WIDTH-1:0] r_quota, w_quota_nxt;
  logic                    r_in_pkt, w_in_pkt_nxt;
  logic [CntW-1:0]         r_idle_cnt, w_idle_cnt_nxt;
  logic                    r_timeout, w_timeout_nxt;

  logic                    w_any_req;
  logic [IdxW-1:0]         w_winner;
  logic [WEIGHT_WIDTH-1:0] w_win_weight;
  logic [WEIGHT_WIDTH-1:0] w_win_quota;
  logic                    w_pkt_done;
  logic                    w_owner_req;
  logic                    w_idle_cond;
  logic                    w_tmo_hit;
  logic                    w_release;

  assign w_any_req   = |i_req;
  assign w_pkt_done  = i_beat && i_last;
  assign w_owner_req = |(i_req & r_grant);
  assign w_idle_cond = !r_in_pkt && !w_owner_req && !i_beat;
  assign w_tmo_hit   = (r_state == StGrant) && w_idle_cond &&
                       (r_idle_cnt == CntW'(TIMEOUT_CNT_MAX - 1));

  // r_last_served is written with the winner at every grant load, so while a
  // source owns the bus it already equals the owner; the scan below therefore
  // puts the current owner last in the release cycle without a separate index.
  always_comb begin
    int unsigned idx;
    logic        found;
    w_winner = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(r_last_served) + k) % NREQ;
      if (!found && i_req[idx]) begin
        w_winner = IdxW'(idx);
        found    = 1'b1;
      end
    end
  end

  assign w_win_weight = i_weight[w_winner*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign w_win_quota  = (w_win_weight == '0) ? WEIGHT_WIDTH'(1) : w_win_weight;

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_last_served_nxt = r_last_served;
    w_quota_nxt       = r_quota;
    w_in_pkt_nxt      = r_in_pkt;
    w_idle_cnt_nxt    = r_idle_cnt;
    w_timeout_nxt     = 1'b0;
    w_release         = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_release = 1'b1;  // idle behaves like a permanent release point
      end
      StGrant: begin
        if (i_beat && !i_last) w_in_pkt_nxt = 1'b1;
        w_idle_cnt_nxt = w_idle_cond ? r_idle_cnt + CntW'(1) : '0;
        if (w_pkt_done) begin
          w_in_pkt_nxt = 1'b0;
          if (r_quota > WEIGHT_WIDTH'(1)) w_quota_nxt = r_quota - WEIGHT_WIDTH'(1);
          else                            w_release   = 1'b1;
        end
        if (w_tmo_hit) begin
          w_release     = 1'b1;
          w_timeout_nxt = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_release) begin
      w_in_pkt_nxt   = 1'b0;
      w_idle_cnt_nxt = '0;
      if (w_any_req) begin
        w_state_nxt       = StGrant;
        w_grant_nxt       = NREQ'(1) << w_winner;
        w_last_served_nxt = w_winner;
        w_quota_nxt       = w_win_quota;
      end else begin
        w_state_nxt = StIdle;
        w_grant_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_grant       <= '0;
      r_last_served <= IdxW'(NREQ - 1);
      r_quota       <= '0;
      r_in_pkt      <= 1'b0;
      r_idle_cnt    <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last_served <= w_last_served_nxt;
      r_quota       <= w_quota_nxt;
      r_in_pkt      <= w_in_pkt_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = |r_grant;
  assign o_timeout     = r_timeout;

`ifdef AXIS_PKT_SCHED_STATS_EN
  logic [15:0] r_stat_pkts [NREQ];
  logic [15:0] r_stat_tmo;

  always_ff @(posedge clk) begin
    if (rst || i_stat_clr) begin
      for (int unsigned i = 0; i < NREQ; i++) r_stat_pkts[i] <= '0;
      r_stat_tmo <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_pkt_done && r_grant[i] && (r_stat_pkts[i] != 16'hFFFF)) begin
          r_stat_pkts[i] <= r_stat_pkts[i] + 16'd1;
        end
      end
      if (w_tmo_hit && (r_stat_tmo != 16'hFFFF)) r_stat_tmo <= r_stat_tmo + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    assign o_stat_pkts[gi*16 +: 16] = r_stat_pkts[gi];
  end
  assign o_stat_timeouts = r_stat_tmo;
`endif

endmodule

// File: tb/tb_axis_pkt_scheduler.sv
module tb_axis_pkt_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        beat;
  logic        last;
  logic [3:0]  grant;
  logic        gv;
  logic        tmo;
`ifdef AXIS_PKT_SCHED_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_pkts;
  logic [15:0] stat_tmo;
`endif

  int total = 0;
  int bad   = 0;

  axis_pkt_scheduler #(
    .NREQ            (4),
    .WEIGHT_WIDTH    (4),
    .TIMEOUT_CNT_MAX (128)
  ) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef AXIS_PKT_SCHED_STATS_EN
    .i_stat_clr      (stat_clr),
    .o_stat_pkts     (stat_pkts),
    .o_stat_timeouts (stat_tmo),
`endif
    .i_req           (req),
    .i_weight        (weight),
    .i_beat          (beat),
    .i_last          (last),
    .o_grant         (grant),
    .o_grant_valid   (gv),
    .o_timeout       (tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant per cycle for weight {1,1,1,3} with back-to-back single-beat packets.
  logic [3:0] wrr_seq [9] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h1, 4'h1};

  initial begin
    rst = 1'b1; req = 4'hF; weight = 16'h1113; beat = 1'b0; last = 1'b0;
`ifdef AXIS_PKT_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset with all sources requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_gv", 32'(gv), 32'h0);
      chk("rst_tmo", 32'(tmo), 32'h0);
    end
    rst = 1'b0;
    chk("rst_release", 32'(grant), 32'h0);
    tick();
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_gv", 32'(gv), 32'h1);

    // Weighted turn: source 0 gets 3 packets, others 1, no bubbles
    beat = 1'b1; last = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk("wrr_seq", 32'(grant), 32'(wrr_seq[i]));
    end

    // Zero weight on source 1, lone requester re-granted
    req = 4'b0010; weight = 16'h1103;
    tick(); chk("zw_grant", 32'(grant), 32'h2);
    tick(); chk("zw_regrant1", 32'(grant), 32'h2);
    tick(); chk("zw_regrant2", 32'(grant), 32'h2);
    req = 4'b0110;
    tick(); chk("zw_one_pkt", 32'(grant), 32'h4);

    // Timeout: source 2 owns, has nothing, source 3 waiting
    req = 4'b1000; beat = 1'b0; last = 1'b0;
    for (int i = 1; i < 128; i++) begin
      tick();
      chk("tmo_early", {27'h0, tmo, grant}, {27'h0, 1'b0, 4'h4});
    end
    tick();
    chk("tmo_pulse", 32'(tmo), 32'h1);
    chk("tmo_regrant", 32'(grant), 32'h8);
    tick();
    chk("tmo_one_cycle", 32'(tmo), 32'h0);

    // Mid-packet stall on source 0
    req = 4'b0001; beat = 1'b1; last = 1'b1;
    tick(); chk("stall_grant", 32'(grant), 32'h1);
    beat = 1'b1; last = 1'b0;
    tick(); chk("stall_first_beat", 32'(grant), 32'h1);
    beat = 1'b0; req = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("stall_hold", {27'h0, tmo, grant}, {27'h0, 1'b0, 4'h1});
    end
    beat = 1'b1; last = 1'b1;
    tick(); chk("stall_done_keep", 32'(grant), 32'h1);

    // Owner still has quota but nothing queued: timeout to idle
    beat = 1'b0; last = 1'b0;
    for (int i = 1; i < 128; i++) begin
      tick();
      chk("idle_tmo_early", {27'h0, tmo, grant}, {27'h0, 1'b0, 4'h1});
    end
    tick();
    chk("idle_tmo_pulse", 32'(tmo), 32'h1);
    chk("idle_tmo_grant", 32'(grant), 32'h0);
    chk("idle_tmo_gv", 32'(gv), 32'h0);

    // Beat in the cycle that would time out wins
    req = 4'b0100;
    tick(); chk("bw_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    for (int i = 1; i < 128; i++) tick();
    chk("bw_pre", {27'h0, tmo, grant}, {27'h0, 1'b0, 4'h4});
    beat = 1'b1; last = 1'b0;
    tick();
    chk("bw_no_tmo", {27'h0, tmo, grant}, {27'h0, 1'b0, 4'h4});
    beat = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("bw_hold", 32'(grant), 32'h4);
    beat = 1'b1; last = 1'b1;
    tick();
    chk("bw_release_idle", 32'(grant), 32'h0);
    chk("bw_release_gv", 32'(gv), 32'h0);

    // Reset mid-packet drops the grant
    req = 4'b0001; beat = 1'b0; last = 1'b0;
    tick(); chk("mr_grant", 32'(grant), 32'h1);
    beat = 1'b1;
    tick();
    beat = 1'b0; rst = 1'b1;
    tick();
    chk("mr_grant_drop", 32'(grant), 32'h0);
    chk("mr_gv_drop", 32'(gv), 32'h0);
    rst = 1'b0; req = 4'b0000;
    tick(); chk("mr_idle", 32'(grant), 32'h0);
    req = 4'b0100;
    tick(); chk("mr_rr_after_rst", 32'(grant), 32'h4);

`ifdef AXIS_PKT_SCHED_STATS_EN
    rst = 1'b1; req = 4'b0000; beat = 1'b0; last = 1'b0;
    tick();
    rst = 1'b0; stat_clr = 1'b1;
    tick();
    chk("stat_clr0", 32'(stat_pkts[31:16]), 32'h0);
    stat_clr = 1'b0; req = 4'b0010; beat = 1'b1; last = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    chk("stat_sat", 32'(stat_pkts[31:16]), 32'hFFFF);
    chk("stat_other", 32'(stat_pkts[15:0]), 32'h0);
    stat_clr = 1'b1;
    tick();
    chk("stat_clr_wins", 32'(stat_pkts[31:16]), 32'h0);
    stat_clr = 1'b0; beat = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
